// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with registered output.
// Fixed-select or round-robin grant; packets are never interleaved.
module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Mode,
  input  logic [SELW-1:0]    Sel,
  input  logic [N*WIDTH-1:0] In_Data,
  input  logic [N-1:0]       In_Valid,
  input  logic [N-1:0]       In_Last,
  output logic [N-1:0]       In_Ready,
  output logic [WIDTH-1:0]   Out_Data,
  output logic               Out_Valid,
  output logic               Out_Last,
  output logic [SELW-1:0]    Out_Chan,
  input  logic               Out_Ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, nstate;

  logic [SELW-1:0] ptr, nptr;
  logic [SELW-1:0] lock_chan, nlock;
  logic [SELW-1:0] g;
  logic            gv;
  logic [SELW-1:0] rr_g;
  logic            rr_hit;
  logic [SELW-1:0] idx;
  logic            can_load;
  logic            xfer;
  logic [WIDTH-1:0] sel_data;
  logic            sel_last;

  // Valid padded to the full Sel range so out-of-range Sel never grants.
  logic [(1<<SELW)-1:0] vpad;

  always_comb begin
    vpad = '0;
    vpad[N-1:0] = In_Valid;
    rr_g = ptr;
    rr_hit = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = SELW'((int'(ptr) + k) % N);
      if (!rr_hit && In_Valid[idx]) begin
        rr_hit = 1'b1;
        rr_g = idx;
      end
    end
  end

  always_comb begin
    g  = '0;
    gv = 1'b0;
    unique case (1'b1)
      state == LOCKED: begin
        g  = lock_chan;
        gv = In_Valid[lock_chan];
      end
      state == IDLE && Mode: begin
        g  = rr_g;
        gv = rr_hit;
      end
      state == IDLE && !Mode: begin
        g  = Sel;
        gv = vpad[Sel];
      end
    endcase
  end

  assign can_load = !Out_Valid || Out_Ready;

  always_comb begin
    In_Ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) begin
        In_Ready[i] = can_load && gv && !Rst;
        sel_data = In_Data[i*WIDTH +: WIDTH];
        sel_last = In_Last[i];
      end
    end
  end

  assign xfer = |(In_Ready & In_Valid);

  always_comb begin
    nstate = state;
    nptr   = ptr;
    nlock  = lock_chan;
    if (xfer) begin
      if (sel_last) begin
        nstate = IDLE;
        nptr   = (g == SELW'(N-1)) ? '0 : SELW'(g + 1'b1);
      end else if (state == IDLE) begin
        nstate = LOCKED;
        nlock  = g;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= '0;
      lock_chan <= '0;
    end else begin
      state     <= nstate;
      ptr       <= nptr;
      lock_chan <= nlock;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Last  <= 1'b0;
      Out_Chan  <= '0;
    end else if (xfer) begin
      Out_Valid <= 1'b1;
      Out_Data  <= sel_data;
      Out_Last  <= sel_last;
      Out_Chan  <= g;
    end else if (Out_Valid && Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of stream_mux_rr (N=4 and N=3).
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_chan;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_last3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_last3;
  logic [1:0]  out_chan3;
  logic        out_ready3;

  int n_chk;
  int n_pass;

  stream_mux_rr #(.WIDTH(8), .N(4)) u_dut (
    .Clk(clk), .Rst(rst), .Mode(mode), .Sel(sel),
    .In_Data(in_data), .In_Valid(in_valid), .In_Last(in_last),
    .In_Ready(in_ready), .Out_Data(out_data), .Out_Valid(out_valid),
    .Out_Last(out_last), .Out_Chan(out_chan), .Out_Ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .N(3)) u_dut3 (
    .Clk(clk), .Rst(rst), .Mode(mode3), .Sel(sel3),
    .In_Data(in_data3), .In_Valid(in_valid3), .In_Last(in_last3),
    .In_Ready(in_ready3), .Out_Data(out_data3), .Out_Valid(out_valid3),
    .Out_Last(out_last3), .Out_Chan(out_chan3), .Out_Ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [7:0] d, input logic l);
    in_data[ch*8 +: 8] = d;
    in_last[ch] = l;
  endtask

  logic [7:0] dtab [4];

  initial begin
    n_chk = 0;
    n_pass = 0;
    dtab[0] = 8'h11; dtab[1] = 8'h22; dtab[2] = 8'h33; dtab[3] = 8'h44;
    rst = 1'b1;
    mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b1111; in_last = 4'b1111;
    mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
    in_data3 = 24'h0; in_valid3 = 3'b000; in_last3 = 3'b111;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    step();
    chk("rst_hold_valid", out_valid, 0);
    rst = 1'b0;

    // fixed select
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("fix_in_ready", in_ready, 4'b0001 << s);
      step();
      chk("fix_data", out_data, dtab[s]);
      chk("fix_chan", out_chan, s);
      step();
    end

    // round robin, all valid, single-beat packets
    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_chan", out_chan, k % 4);
      chk("rr_data", out_data, dtab[k % 4]);
    end

    // packet lock in round robin
    in_valid = 4'b0110;
    put(1, 8'hA0, 1'b0);
    put(2, 8'hB0, 1'b1);
    #1;
    chk("lock_rr_ready0", in_ready, 4'b0010);
    step();
    chk("lock_rr_a0", out_data, 8'hA0);
    put(1, 8'hA1, 1'b0);
    #1;
    chk("lock_rr_ready1", in_ready, 4'b0010);
    step();
    chk("lock_rr_a1", out_data, 8'hA1);
    chk("lock_rr_a1_chan", out_chan, 1);
    put(1, 8'hA2, 1'b1);
    step();
    chk("lock_rr_a2", out_data, 8'hA2);
    chk("lock_rr_a2_last", out_last, 1);
    in_valid = 4'b0100;
    step();
    chk("lock_rr_b0", out_data, 8'hB0);
    chk("lock_rr_b0_chan", out_chan, 2);
    in_valid = 4'b0000;
    step();
    chk("lock_rr_drain", out_valid, 0);

    // packet lock in fixed mode, Sel moved mid-packet
    mode = 1'b0; sel = 2'd1;
    in_valid = 4'b1010;
    put(1, 8'hA0, 1'b0);
    put(3, 8'hC0, 1'b1);
    step();
    chk("lock_fx_a0", out_data, 8'hA0);
    sel = 2'd3;
    put(1, 8'hA1, 1'b0);
    #1;
    chk("lock_fx_ready", in_ready, 4'b0010);
    step();
    chk("lock_fx_a1", out_data, 8'hA1);
    chk("lock_fx_a1_chan", out_chan, 1);
    put(1, 8'hA2, 1'b1);
    step();
    chk("lock_fx_a2", out_data, 8'hA2);
    in_valid = 4'b1000;
    step();
    chk("lock_fx_c0", out_data, 8'hC0);
    chk("lock_fx_c0_chan", out_chan, 3);
    in_valid = 4'b0000;
    step();
    chk("lock_fx_drain", out_valid, 0);

    // back-pressure
    sel = 2'd0;
    in_valid = 4'b0001;
    put(0, 8'h5A, 1'b1);
    step();
    chk("bp_load", out_data, 8'h5A);
    out_ready = 1'b0;
    put(0, 8'h5B, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 4'b0000);
      step();
      chk("bp_hold_data", out_data, 8'h5A);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 4'b0001);
    step();
    chk("bp_next", out_data, 8'h5B);
    put(0, 8'h5C, 1'b1);
    step();
    chk("bp_next2", out_data, 8'h5C);
    in_valid = 4'b0000;
    step();
    chk("bp_drain", out_valid, 0);

    // reset mid-packet
    mode = 1'b1;
    in_valid = 4'b0100;
    put(2, 8'h77, 1'b0);
    step();
    chk("rmp_lock", out_chan, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("rmp_valid", out_valid, 0);
    chk("rmp_in_ready", in_ready, 4'b0000);
    in_valid = 4'b0101;
    put(0, 8'h99, 1'b1);
    put(2, 8'h78, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk("rmp_grant", in_ready, 4'b0001);
    step();
    chk("rmp_chan", out_chan, 0);
    chk("rmp_data", out_data, 8'h99);
    in_valid = 4'b0000;
    step();

    // out-of-range Sel on N=3
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    in_data3 = {8'hC3, 8'hC2, 8'hC1};
    #1;
    chk("oor_in_ready", in_ready3, 3'b000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("oor_valid", out_valid3, 0);
    end
    sel3 = 2'd2;
    #1;
    chk("n3_in_ready", in_ready3, 3'b100);
    step();
    chk("n3_chan", out_chan3, 2);
    chk("n3_data", out_data3, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes, a registered output stage and packet-aware arbitration. It generalises the 4:1 combinational MUX into a sequential block for the datapath. The block runs in fixed-select mode (software-chosen channel, as in the plain MUX) or round-robin mode. It never interleaves beats of different packets.

## Interface
- WIDTH, 8: data width per channel.
- N, 4: number of input channels, N >= 2.
- SELW, $clog2(N): channel-index width (derived, not overridden).

- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Mode  in  1  0 = fixed select, 1 = round-robin.
- Sel  in  SELW  channel granted in fixed mode.
- In_Data  in  N*WIDTH  channel i at [i*WIDTH +: WIDTH].
- In_Valid  in  N  per-channel beat valid.
- In_Last  in  N  per-channel last beat of packet.
- In_Ready  out  N  per-channel accept, one-hot or zero.
- Out_Data  out  WIDTH  registered output beat.
- Out_Valid  out  1  output beat valid.
- Out_Last  out  1  output beat is packet end.
- Out_Chan  out  SELW  source channel of the output beat.
- Out_Ready  in  1  downstream accept.

## Operation
- Output register: single entry. can_load = !Out_Valid || Out_Ready.
- Grant g is computed combinationally. In_Ready[i] = can_load && grant_valid && (i == g). At most one bit is set.
- Input transfer occurs when In_Valid[g] && In_Ready[g]. On transfer the register loads In_Data[g], In_Last[g] and g, and sets Out_Valid=1.
- Output transfer (Out_Valid && Out_Ready) with no input transfer clears Out_Valid.
- FSM states:
  - IDLE: no packet open.
  - LOCKED: a packet is open on Lock_Chan.
- IDLE, Mode=0: g=Sel; grant_valid = In_Valid[Sel] && Sel < N. If Sel >= N there is never a grant.
- IDLE, Mode=1: g = first i with In_Valid[i], searching Ptr, Ptr+1, … wrapping mod N. grant_valid = |In_Valid.
- LOCKED: g=Lock_Chan; grant_valid=In_Valid[Lock_Chan]. Mode and Sel are ignored.
- Transfer with In_Last=0 in IDLE: go to LOCKED, Lock_Chan=g.
- Transfer with In_Last=1 (either state): go to IDLE and set Ptr=(g+1) mod N. Ptr updates in both modes.
- Single-beat packet (In_Last=1 in IDLE): the FSM stays IDLE.
- Mode and Sel changes take effect only in IDLE, at a packet boundary.
- In_Valid[i] is never required to stay high. Deasserting it mid-packet stalls the output and the lock holds.

## Timing
- Reset values: Out_Valid=0, Out_Data=0, Out_Last=0, Out_Chan=0, state=IDLE, Ptr=0, Lock_Chan=0.
- While Rst=1, In_Ready=0.
- Latency: a beat accepted at edge k appears on Out_* immediately after edge k.
- Throughput: 1 beat/cycle with Out_Ready held high.
- Back-pressure: while Out_Valid && !Out_Ready, all Out_* are stable and In_Ready=0.
- Simultaneous output and input transfer in the same cycle: the register reloads with no bubble.
- Reset mid-packet: all state clears asynchronously and the in-flight beat is dropped. The first grant after release uses Ptr=0.
- Combinational paths: Out_Ready → In_Ready and In_Valid → In_Ready. There is no path into Out_*.

## Test plan
(WIDTH=8, N=4 unless stated.)
1. Fixed mode: Mode=0, D0..D3=11,22,33,44 all valid, Last=1, Out_Ready=1, Sel=0,1,2,3 each held 2 cycles → Out_Data 11,22,33,44 with Out_Chan = Sel, one cycle after each accept.
2. Round-robin fairness: Mode=1, all channels valid, Last=1, Out_Ready=1 for 8 cycles → Out_Chan 0,1,2,3,0,1,2,3, each beat carrying that channel's data.
3. Packet lock: Mode=1, ch1 sends A0,A1,A2 (Last on A2) while ch2 valid with B0 → output A0,A1,A2 contiguous, then B0. Repeat in Mode=0 with Sel changed 1→3 after A0 → A1,A2 still from ch1, then ch3.
4. Back-pressure: Out_Ready=0 for 3 cycles with Out_Valid=1, data 5A → Out_Data=5A held and In_Ready=0000. Release → next beats follow with no loss or duplication.
5. Reset mid-packet: lock ch2, assert Rst between edges → Out_Valid=0 immediately. After release with ch0 and ch2 valid, ch0 is granted first.
6. Out-of-range Sel: N=3, Mode=0, Sel=3, all valid → In_Ready=000 and Out_Valid stays 0.
